// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
//
// Retired-store write buffer between the store queue / ROB retire path and the
// memory bus. Each retired store is captured into a DEPTH-entry FIFO and
// drained in order, so store retirement never waits on memory latency. Loads
// look the buffer up combinationally and get byte-wise forwarding from pending
// stores (youngest store wins per byte lane).
//
// Optional feature macro: WB_COALESCE_EN. When defined, a store to the same
// word as the youngest pending entry merges into it instead of allocating,
// provided that entry is not the head currently on the bus and the merged
// byte mask is still a legal BYTE/HALF/WORD pattern.
//
// Ports:
//   clock                 system clock, posedge
//   reset                 asynchronous, active-high; clears all state
//   proc2dcache_req_store store request {action, addr, data, size}
//   ld_addr               word address of the executing load
//   ld_fwd_value          forwarded bytes, lane-aligned (zero in unmatched lanes)
//   ld_fwd_mask           lanes valid in ld_fwd_value
//   wb_full / wb_empty    occupancy flags (count==DEPTH / count==0)
//   overflow_err          sticky: a push was dropped because the buffer was full
//   proc2mem_command      BUS_STORE while a drain is outstanding, else BUS_NONE
//   proc2mem_addr/data/size  drained store, data right-aligned
//   mem2proc_response     nonzero = command accepted this cycle
//   dbg_state             drain FSM state
//
// Bus handshake: proc2mem_command==BUS_STORE acts as "valid" and a nonzero
// mem2proc_response acts as "ready". While valid is high, addr/data/size are
// held stable; the transfer happens on the clock edge where both are high,
// and only then is the head entry popped.

`ifndef XLEN
`define XLEN 32
`endif

package dcache_wb_pkg;
  typedef enum logic [1:0] {BYTE = 2'h0, HALF = 2'h1, WORD = 2'h2, DOUBLE = 2'h3} MEM_SIZE;
  typedef enum logic [1:0] {BUS_NONE = 2'h0, BUS_LOAD = 2'h1, BUS_STORE = 2'h2} BUS_COMMAND;
  typedef enum logic [1:0] {REQ_NONE = 2'h0, REQ_LOAD = 2'h1, REQ_STORE = 2'h2} PROC2DCACHE_ACTION;

  typedef struct packed {
    PROC2DCACHE_ACTION action;
    logic [`XLEN-1:0]  addr;
    logic [`XLEN-1:0]  data;
    MEM_SIZE           size;
  } PROC2DCACHE_REG;

  typedef enum logic {WB_IDLE = 1'b0, WB_REQ = 1'b1} wb_state_e;
endpackage

module dcache_write_buffer
  import dcache_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  PROC2DCACHE_REG      proc2dcache_req_store,
  input  logic [`XLEN-3:0]    ld_addr,
  output logic [`XLEN-1:0]    ld_fwd_value,
  output logic [3:0]          ld_fwd_mask,
  output logic                wb_full,
  output logic                wb_empty,
  output logic                overflow_err,
  output BUS_COMMAND          proc2mem_command,
  output logic [`XLEN-1:0]    proc2mem_addr,
  output logic [`XLEN-1:0]    proc2mem_data,
  output MEM_SIZE             proc2mem_size,
  input  logic [3:0]          mem2proc_response,
  output wb_state_e           dbg_state
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WA_W  = `XLEN - 2;

  typedef struct packed {
    logic             valid;
    logic [WA_W-1:0]  waddr;
    logic [3:0]       mask;
    logic [`XLEN-1:0] data;   // lane-aligned, unmasked lanes are zero
  } wb_entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [PTR_W-1:0] p);
    return p[IDX_W-1:0];
  endfunction

  function automatic logic [`XLEN-1:0] lane_bits(input logic [3:0] m);
    return `XLEN'({{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}});
  endfunction

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b0110, 4'b1100, 4'b1111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  // State
  wb_entry_t        mem   [DEPTH];
  wb_entry_t        mem_n [DEPTH];
  logic [PTR_W-1:0] head, tail, count;
  logic [PTR_W-1:0] head_n, tail_n, count_n;
  wb_state_e        state;

  // Request decode
  logic             push_req;
  logic [1:0]       req_off;
  logic [3:0]       req_mask;
  logic [`XLEN-1:0] req_lanes;
  logic [`XLEN-1:0] req_data;
  logic [WA_W-1:0]  req_waddr;

  assign push_req  = (proc2dcache_req_store.action == REQ_STORE);
  assign req_off   = proc2dcache_req_store.addr[1:0];
  assign req_waddr = proc2dcache_req_store.addr[`XLEN-1:2];

  always_comb begin
    req_mask = 4'b1111;
    case (proc2dcache_req_store.size)
      BYTE:    req_mask = 4'b0001 << req_off;
      HALF:    req_mask = 4'b0011 << req_off;
      default: req_mask = 4'b1111;
    endcase
  end

  assign req_lanes = lane_bits(req_mask);
  assign req_data  = (proc2dcache_req_store.data << {req_off, 3'b000}) & req_lanes;

  logic accept;
  logic merge_ok;
  logic alloc;
  logic drop;

  assign accept = (state == WB_REQ) && (mem2proc_response != 4'd0);

`ifdef WB_COALESCE_EN
  logic [PTR_W-1:0] young_ptr;
  wb_entry_t        young_ent;
  logic [3:0]       merge_mask;
  logic [`XLEN-1:0] merge_data;

  assign young_ptr  = (tail == '0) ? PTR_W'(DEPTH - 1) : tail - PTR_W'(1);
  assign young_ent  = mem[idx(young_ptr)];
  assign merge_mask = young_ent.mask | req_mask;
  assign merge_data = (young_ent.data & ~req_lanes) | req_data;
  // With a single entry in REQ the youngest entry is the one on the bus; its
  // outputs are frozen, so it must not change underneath the handshake.
  assign merge_ok   = push_req && (count != '0) && young_ent.valid &&
                      (young_ent.waddr == req_waddr) &&
                      !((state == WB_REQ) && (count == PTR_W'(1))) &&
                      mask_legal(merge_mask);
`else
  assign merge_ok = 1'b0;
`endif

  // Full check uses the registered count: a pop in the same cycle does not
  // make room, matching what the ROB saw on wb_full.
  assign alloc = push_req && !merge_ok && (count != PTR_W'(DEPTH));
  assign drop  = push_req && !merge_ok && (count == PTR_W'(DEPTH));

  // Next-cycle FIFO contents, so the drain FSM can load the bus registers
  // straight from whichever entry will be the head next cycle (including a
  // store pushed this very cycle).
  always_comb begin
    mem_n   = mem;
    head_n  = head;
    tail_n  = tail;
    if (accept) begin
      mem_n[idx(head)].valid = 1'b0;
      head_n = ptr_inc(head);
    end
`ifdef WB_COALESCE_EN
    if (merge_ok) begin
      mem_n[idx(young_ptr)].mask = merge_mask;
      mem_n[idx(young_ptr)].data = merge_data;
    end
`endif
    if (alloc) begin
      mem_n[idx(tail)] = '{valid: 1'b1, waddr: req_waddr, mask: req_mask, data: req_data};
      tail_n = ptr_inc(tail);
    end
    count_n = count + PTR_W'(alloc) - PTR_W'(accept);
  end

  // Drained size/offset are recovered from the byte mask.
  logic [1:0]       nxt_off;
  MEM_SIZE          nxt_size;
  logic [3:0]       nxt_mask;
  logic [`XLEN-1:0] nxt_addr;
  logic [`XLEN-1:0] nxt_data;

  assign nxt_mask = mem_n[idx(head_n)].mask;

  always_comb begin
    nxt_off  = 2'd0;
    nxt_size = WORD;
    case (nxt_mask)
      4'b0001: begin nxt_size = BYTE; nxt_off = 2'd0; end
      4'b0010: begin nxt_size = BYTE; nxt_off = 2'd1; end
      4'b0100: begin nxt_size = BYTE; nxt_off = 2'd2; end
      4'b1000: begin nxt_size = BYTE; nxt_off = 2'd3; end
      4'b0011: begin nxt_size = HALF; nxt_off = 2'd0; end
      4'b0110: begin nxt_size = HALF; nxt_off = 2'd1; end
      4'b1100: begin nxt_size = HALF; nxt_off = 2'd2; end
      default: begin nxt_size = WORD; nxt_off = 2'd0; end
    endcase
  end

  assign nxt_addr = {mem_n[idx(head_n)].waddr, nxt_off};
  assign nxt_data = mem_n[idx(head_n)].data >> {nxt_off, 3'b000};

  // FIFO registers and drain FSM with registered bus outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      overflow_err     <= 1'b0;
      state            <= WB_IDLE;
      proc2mem_command <= BUS_NONE;
      proc2mem_addr    <= '0;
      proc2mem_data    <= '0;
      proc2mem_size    <= BYTE;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_n[i];
      head  <= head_n;
      tail  <= tail_n;
      count <= count_n;
      if (drop) overflow_err <= 1'b1;

      case (state)
        WB_IDLE: begin
          if (count_n != '0) begin
            state            <= WB_REQ;
            proc2mem_command <= BUS_STORE;
            proc2mem_addr    <= nxt_addr;
            proc2mem_data    <= nxt_data;
            proc2mem_size    <= nxt_size;
          end
        end
        WB_REQ: begin
          // Outputs hold until the memory accepts.
          if (accept) begin
            if (count_n != '0) begin
              proc2mem_command <= BUS_STORE;
              proc2mem_addr    <= nxt_addr;
              proc2mem_data    <= nxt_data;
              proc2mem_size    <= nxt_size;
            end else begin
              state            <= WB_IDLE;
              proc2mem_command <= BUS_NONE;
              proc2mem_addr    <= '0;
              proc2mem_data    <= '0;
              proc2mem_size    <= BYTE;
            end
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // Load forwarding: walk slots oldest to youngest starting at head so a
  // younger match overwrites an older one lane by lane.
  logic [PTR_W:0] fwd_slot;
  wb_entry_t      fwd_ent;

  always_comb begin
    ld_fwd_value = '0;
    ld_fwd_mask  = 4'b0000;
    fwd_slot     = '0;
    fwd_ent      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_slot = {1'b0, head} + (PTR_W + 1)'(k);
      if (fwd_slot >= (PTR_W + 1)'(DEPTH)) fwd_slot = fwd_slot - (PTR_W + 1)'(DEPTH);
      fwd_ent = mem[fwd_slot[IDX_W-1:0]];
      for (int j = 0; j < 4; j++) begin
        if (fwd_ent.valid && (fwd_ent.waddr == ld_addr) && fwd_ent.mask[j]) begin
          ld_fwd_mask[j]        = 1'b1;
          ld_fwd_value[8*j +: 8] = fwd_ent.data[8*j +: 8];
        end
      end
    end
  end

  assign wb_full   = (count == PTR_W'(DEPTH));
  assign wb_empty  = (count == '0);
  assign dbg_state = state;

endmodule
